// File: rtl/bp_be_pkg.sv
// Shared types for the loop trip estimator: processor config, branch compare and state enums.
// Also holds the operand-distance helper used by every channel.
package bp_be_pkg;

   typedef enum logic [0:0] {e_bp_default_cfg} bp_params_e;

   localparam int dpath_width_gp = 64;
   localparam int dword_width_gp = 64;

   typedef enum logic [2:0] {
      e_br_eq,
      e_br_ne,
      e_br_lt,
      e_br_ge,
      e_br_ltu,
      e_br_geu
   } bp_be_loop_br_e;

   typedef enum logic [2:0] {
      e_st_idle,
      e_st_seek,
      e_st_armed,
      e_st_calc,
      e_st_div,
      e_st_hold,
      e_st_ready
   } bp_be_loop_state_e;

   typedef enum logic [1:0] {
      e_div_idle,
      e_div_busy,
      e_div_done
   } bp_be_div_state_e;

   function automatic int bp_vaddr_width(bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return 39;
         default:          return 39;
      endcase
   endfunction

   // Magnitude of a two's-complement difference.
   function automatic logic [dpath_width_gp-1:0] abs_diff(logic [dpath_width_gp-1:0] x,
                                                          logic [dpath_width_gp-1:0] y);
      logic [dpath_width_gp-1:0] d;
      d = x - y;
      return d[dpath_width_gp-1] ? (~d + 1'b1) : d;
   endfunction

endpackage

// File: rtl/bp_be_loop_trip_div.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
// Result is valid for one cycle, width_p+1 cycles after the accepting cycle.
module bp_be_loop_trip_div
   import bp_be_pkg::*;
#(
   parameter int width_p = dpath_width_gp
)(
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   output logic               ready_o,
   input  logic [width_p-1:0] dividend_i,
   input  logic [width_p-1:0] divisor_i,
   output logic               v_o,
   output logic [width_p-1:0] quotient_o
);

   localparam int cnt_width_lp = $clog2(width_p);

   bp_be_div_state_e         r_state;
   logic [cnt_width_lp-1:0]  r_cnt;
   logic [width_p-1:0]       r_rem;
   logic [width_p-1:0]       r_quot;
   logic [width_p-1:0]       r_divisor;

   logic [width_p:0]         w_rem_sh;
   logic [width_p:0]         w_rem_sub;
   logic                     w_ge;

   assign w_rem_sh  = {r_rem, r_quot[width_p-1]};
   assign w_rem_sub = w_rem_sh - {1'b0, r_divisor};
   assign w_ge      = (w_rem_sh >= {1'b0, r_divisor});

   assign ready_o    = (r_state == e_div_idle);
   assign v_o        = (r_state == e_div_done);
   assign quotient_o = r_quot;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state   <= e_div_idle;
         r_cnt     <= '0;
         r_rem     <= '0;
         r_quot    <= '0;
         r_divisor <= '0;
      end else begin
         unique case (r_state)
            e_div_idle: begin
               if (v_i) begin
                  r_state   <= e_div_busy;
                  r_cnt     <= '0;
                  r_rem     <= '0;
                  r_quot    <= dividend_i;
                  r_divisor <= divisor_i;
               end
            end
            e_div_busy: begin
               r_rem  <= w_ge ? w_rem_sub[width_p-1:0] : w_rem_sh[width_p-1:0];
               r_quot <= {r_quot[width_p-2:0], w_ge};
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == cnt_width_lp'(width_p - 1)) begin
                  r_state <= e_div_done;
               end
            end
            e_div_done: r_state <= e_div_idle;
            default:    r_state <= e_div_idle;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i && v_i && ready_o) begin
         assert (divisor_i != '0);
      end
   end

endmodule

// File: rtl/bp_be_loop_trip_estimator.sv
// Multi-channel loop trip-count estimator: each channel finds the enclosing backward branch,
// samples its operands twice and divides the remaining distance by the per-iteration stride.
module bp_be_loop_trip_estimator
   import bp_be_pkg::*;
#(
   parameter bp_params_e bp_params_p    = e_bp_default_cfg,
   parameter int         channels_p     = 2,
   parameter int         output_range_p = 8,
   parameter int         default_trip_p = 128,
   localparam int        vaddr_width_p  = bp_vaddr_width(bp_params_p),
   localparam int        id_width_lp    = (channels_p > 1) ? $clog2(channels_p) : 1
)(
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      br_v_i,
   input  logic [vaddr_width_p-1:0]  br_pc_i,
   input  bp_be_loop_br_e            br_op_i,
   input  logic [dword_width_gp-1:0] br_imm_i,
   input  logic [dpath_width_gp-1:0] rs1_i,
   input  logic [dpath_width_gp-1:0] rs2_i,
   input  logic                      start_v_i,
   input  logic [id_width_lp-1:0]    start_id_i,
   input  logic [vaddr_width_p-1:0]  striding_pc_i,
   input  logic                      confirm_v_i,
   input  logic [id_width_lp-1:0]    confirm_id_i,
   output logic                      v_o,
   output logic [id_width_lp-1:0]    id_o,
   output logic [output_range_p-1:0] trip_o,
   input  logic                      yumi_i
);

   bp_be_loop_state_e         r_state  [channels_p];
   logic                      r_lock   [channels_p];
   logic                      r_granted[channels_p];
   logic [vaddr_width_p-1:0]  r_spc    [channels_p];
   logic [vaddr_width_p-1:0]  r_pc     [channels_p];
   bp_be_loop_br_e            r_op     [channels_p];
   logic [dpath_width_gp-1:0] r_a1     [channels_p];
   logic [dpath_width_gp-1:0] r_b1     [channels_p];
   logic [dpath_width_gp-1:0] r_a2     [channels_p];
   logic [dpath_width_gp-1:0] r_b2     [channels_p];
   logic [dpath_width_gp-1:0] r_dist   [channels_p];
   logic [dpath_width_gp-1:0] r_stride [channels_p];
   logic [output_range_p-1:0] r_trip   [channels_p];
   logic [id_width_lp-1:0]    r_owner;

   logic                      r_v_o;
   logic [id_width_lp-1:0]    r_id_o;
   logic [output_range_p-1:0] r_trip_o;

   logic [channels_p-1:0]     w_start_hit;
   logic [channels_p-1:0]     w_confirm_hit;
   logic [channels_p-1:0]     w_yumi_hit;
   logic [channels_p-1:0]     w_grant;
   logic [channels_p-1:0]     w_rdy_next;
   logic                      w_sel_v;
   logic [id_width_lp-1:0]    w_sel_id;
   logic                      w_div_v;
   logic [id_width_lp-1:0]    w_grant_id;
   logic [dpath_width_gp-1:0] w_div_dividend;
   logic [dpath_width_gp-1:0] w_div_divisor;
   logic                      w_div_ready;
   logic                      w_div_done;
   logic [dpath_width_gp-1:0] w_div_quot;

   logic [dword_width_gp-1:0] w_br_target;
   logic                      w_br_swap;

   assign w_br_target = ({{(dword_width_gp - vaddr_width_p){1'b0}}, br_pc_i} + br_imm_i)
                        & ~dword_width_gp'(1);
   assign w_br_swap   = (br_op_i == e_br_lt) || (br_op_i == e_br_ltu);

   function automatic logic [output_range_p-1:0] sat_trip(logic [dpath_width_gp-1:0] q);
      if (q > dpath_width_gp'({output_range_p{1'b1}})) return '1;
      return q[output_range_p-1:0];
   endfunction

   // Iterating downwards lets the lowest index win both the divider grant and the output mux.
   always_comb begin
      w_div_v        = 1'b0;
      w_grant_id     = '0;
      w_div_dividend = '0;
      w_div_divisor  = '0;
      w_sel_v        = 1'b0;
      w_sel_id       = '0;
      w_start_hit    = '0;
      w_confirm_hit  = '0;
      w_yumi_hit     = '0;
      w_rdy_next     = '0;
      w_grant        = '0;
      for (int c = channels_p - 1; c >= 0; c--) begin
         w_start_hit[c]   = start_v_i && (start_id_i == id_width_lp'(c));
         w_confirm_hit[c] = confirm_v_i && (confirm_id_i == id_width_lp'(c));
         w_yumi_hit[c]    = yumi_i && r_v_o && (r_id_o == id_width_lp'(c));
         w_rdy_next[c]    = ((r_state[c] == e_st_hold) && r_lock[c]) ||
                            ((r_state[c] == e_st_ready) && !w_yumi_hit[c]);
         if (w_rdy_next[c]) begin
            w_sel_v  = 1'b1;
            w_sel_id = id_width_lp'(c);
         end
         if ((r_state[c] == e_st_div) && !r_granted[c] && w_div_ready) begin
            w_div_v        = 1'b1;
            w_grant_id     = id_width_lp'(c);
            w_div_dividend = r_dist[c];
            w_div_divisor  = r_stride[c];
         end
      end
      for (int c = 0; c < channels_p; c++) begin
         w_grant[c] = w_div_v && (w_grant_id == id_width_lp'(c));
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int c = 0; c < channels_p; c++) begin
            r_state[c]   <= e_st_idle;
            r_lock[c]    <= 1'b0;
            r_granted[c] <= 1'b0;
            r_spc[c]     <= '0;
            r_pc[c]      <= '0;
            r_op[c]      <= e_br_eq;
            r_a1[c]      <= '0;
            r_b1[c]      <= '0;
            r_a2[c]      <= '0;
            r_b2[c]      <= '0;
            r_dist[c]    <= '0;
            r_stride[c]  <= '0;
            r_trip[c]    <= '0;
         end
         r_owner  <= '0;
         r_v_o    <= 1'b0;
         r_id_o   <= '0;
         r_trip_o <= '0;
      end else begin
         for (int c = 0; c < channels_p; c++) begin
            if (w_yumi_hit[c]) begin
               r_state[c] <= e_st_idle;
               r_lock[c]  <= 1'b0;
            end else if (w_start_hit[c] && !r_lock[c]) begin
               r_state[c]   <= e_st_seek;
               r_lock[c]    <= w_confirm_hit[c];
               r_granted[c] <= 1'b0;
               r_spc[c]     <= striding_pc_i;
               r_pc[c]      <= '0;
               r_op[c]      <= e_br_eq;
               r_a1[c]      <= '0;
               r_b1[c]      <= '0;
               r_a2[c]      <= '0;
               r_b2[c]      <= '0;
               r_dist[c]    <= '0;
               r_stride[c]  <= '0;
               r_trip[c]    <= '0;
            end else begin
               if (w_confirm_hit[c] && (r_state[c] != e_st_idle)) r_lock[c] <= 1'b1;
               unique case (r_state[c])
                  e_st_idle: ;
                  e_st_seek: begin
                     if (br_v_i && br_imm_i[dword_width_gp-1] &&
                         (w_br_target <= {{(dword_width_gp - vaddr_width_p){1'b0}}, r_spc[c]}))
                     begin
                        r_pc[c]    <= br_pc_i;
                        r_op[c]    <= br_op_i;
                        r_a1[c]    <= w_br_swap ? rs2_i : rs1_i;
                        r_b1[c]    <= w_br_swap ? rs1_i : rs2_i;
                        r_state[c] <= e_st_armed;
                     end
                  end
                  e_st_armed: begin
                     if (br_v_i && (br_pc_i == r_pc[c])) begin
                        if ((r_op[c] == e_br_lt) || (r_op[c] == e_br_ltu)) begin
                           r_a2[c] <= rs2_i;
                           r_b2[c] <= rs1_i;
                        end else begin
                           r_a2[c] <= rs1_i;
                           r_b2[c] <= rs2_i;
                        end
                        r_state[c] <= e_st_calc;
                     end
                  end
                  e_st_calc: begin
                     // Exactly one operand must move per iteration for the count to be defined.
                     if ((r_a2[c] != r_a1[c]) == (r_b2[c] != r_b1[c])) begin
                        r_trip[c]  <= output_range_p'(default_trip_p);
                        r_state[c] <= e_st_hold;
                     end else begin
                        r_dist[c]   <= abs_diff(r_a2[c], r_b2[c]);
                        r_stride[c] <= (r_a2[c] != r_a1[c]) ? abs_diff(r_a2[c], r_a1[c])
                                                            : abs_diff(r_b2[c], r_b1[c]);
                        r_state[c]  <= e_st_div;
                     end
                  end
                  e_st_div: begin
                     if (w_grant[c]) begin
                        r_granted[c] <= 1'b1;
                     end else if (r_granted[c] && w_div_done &&
                                  (r_owner == id_width_lp'(c))) begin
                        r_granted[c] <= 1'b0;
                        r_trip[c]    <= sat_trip(w_div_quot);
                        r_state[c]   <= e_st_hold;
                     end
                  end
                  e_st_hold: begin
                     if (r_lock[c]) r_state[c] <= e_st_ready;
                  end
                  e_st_ready: ;
                  default: r_state[c] <= e_st_idle;
               endcase
            end
         end
         if (w_div_v) r_owner <= w_grant_id;
         // Outputs track the post-edge channel states so a freed slot is refilled at once.
         r_v_o    <= w_sel_v;
         r_id_o   <= w_sel_v ? w_sel_id : '0;
         r_trip_o <= w_sel_v ? r_trip[w_sel_id] : '0;
      end
   end

   assign v_o    = r_v_o;
   assign id_o   = r_id_o;
   assign trip_o = r_trip_o;

   bp_be_loop_trip_div #(
      .width_p(dpath_width_gp)
   ) u_div (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .v_i       (w_div_v),
      .ready_o   (w_div_ready),
      .dividend_i(w_div_dividend),
      .divisor_i (w_div_divisor),
      .v_o       (w_div_done),
      .quotient_o(w_div_quot)
   );

endmodule

// File: tb/tb_bp_be_loop_trip_estimator.sv
// Scoreboard bench for the loop trip estimator: directed loops push expected results,
// a monitor pops and compares whenever a result is presented.
module tb_bp_be_loop_trip_estimator;
   import bp_be_pkg::*;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        br_v;
   logic [38:0] br_pc;
   bp_be_loop_br_e br_op;
   logic [63:0] br_imm;
   logic [63:0] rs1;
   logic [63:0] rs2;
   logic        start_v;
   logic [0:0]  start_id;
   logic [38:0] striding_pc;
   logic        confirm_v;
   logic [0:0]  confirm_id;
   logic        v_o;
   logic [0:0]  id_o;
   logic [7:0]  trip_o;
   logic        yumi;
   logic        hold_yumi;

   typedef struct packed {
      logic [0:0] id;
      logic [7:0] trip;
   } exp_t;
   exp_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   bp_be_loop_trip_estimator dut (
      .clk_i        (clk),
      .reset_i      (reset_i),
      .br_v_i       (br_v),
      .br_pc_i      (br_pc),
      .br_op_i      (br_op),
      .br_imm_i     (br_imm),
      .rs1_i        (rs1),
      .rs2_i        (rs2),
      .start_v_i    (start_v),
      .start_id_i   (start_id),
      .striding_pc_i(striding_pc),
      .confirm_v_i  (confirm_v),
      .confirm_id_i (confirm_id),
      .v_o          (v_o),
      .id_o         (id_o),
      .trip_o       (trip_o),
      .yumi_i       (yumi)
   );

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Monitor: consume each presented result unless the stimulus is holding yumi off.
   initial begin
      exp_t e;
      yumi = 1'b0;
      forever begin
         @(negedge clk);
         yumi = 1'b0;
         if (!reset_i && v_o && !hold_yumi) begin
            if (exp_q.size() == 0) begin
               check("unexpected_v_o", v_o, 0);
            end else begin
               e = exp_q.pop_front();
               check("id_o", id_o, e.id);
               check("trip_o", trip_o, e.trip);
            end
            yumi = 1'b1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_branch(logic [38:0] pc, bp_be_loop_br_e op, logic [63:0] imm,
                            logic [63:0] a, logic [63:0] b);
      br_v = 1'b1; br_pc = pc; br_op = op; br_imm = imm; rs1 = a; rs2 = b;
      @(negedge clk);
      br_v = 1'b0;
   endtask

   task automatic do_start(logic [0:0] id, logic [38:0] spc);
      start_v = 1'b1; start_id = id; striding_pc = spc;
      @(negedge clk);
      start_v = 1'b0;
   endtask

   task automatic do_confirm(logic [0:0] id);
      confirm_v = 1'b1; confirm_id = id;
      @(negedge clk);
      confirm_v = 1'b0;
   endtask

   task automatic drain(int max_cyc, string name);
      int cyc = 0;
      while (exp_q.size() != 0 && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_drain_pending"}, exp_q.size(), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int cyc;
      int seen;
      reset_i = 1'b1; br_v = 1'b0; br_pc = '0; br_op = e_br_eq; br_imm = '0;
      rs1 = '0; rs2 = '0; start_v = 1'b0; start_id = '0; striding_pc = '0;
      confirm_v = 1'b0; confirm_id = '0; hold_yumi = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_v_o", v_o, 0);
      check("reset_id_o", id_o, 0);
      check("reset_trip_o", trip_o, 0);
      reset_i = 1'b0;
      @(negedge clk);

      // 1: bge forward loop, with decoy branches that must be ignored.
      exp_q.push_back('{id: 1'b0, trip: 8'd96});
      do_start(1'b0, 39'h1000);
      do_confirm(1'b0);
      do_branch(39'h1040, e_br_ge, 64'h40, 7, 7);
      do_branch(39'h1100, e_br_ge, 64'hFFFF_FFFF_FFFF_FFC0, 9, 9);
      do_branch(39'h1040, e_br_ge, 64'hFFFF_FFFF_FFFF_FFC0, 3, 100);
      do_branch(39'h1080, e_br_ge, 64'hFFFF_FFFF_FFFF_FFC0, 50, 50);
      do_branch(39'h1040, e_br_ge, 64'hFFFF_FFFF_FFFF_FFC0, 4, 100);
      drain(200, "t1");

      // 2: bltu swapped into ge form on channel 1.
      exp_q.push_back('{id: 1'b1, trip: 8'd124});
      do_start(1'b1, 39'h2000);
      do_confirm(1'b1);
      do_branch(39'h2080, e_br_ltu, 64'hFFFF_FFFF_FFFF_FF80, 1000, 0);
      do_branch(39'h2080, e_br_ltu, 64'hFFFF_FFFF_FFFF_FF80, 1000, 8);
      drain(200, "t2");

      // 3: both operands move; result held until confirm, and no divider pass.
      do_start(1'b0, 39'h3000);
      do_branch(39'h3010, e_br_ge, 64'hFFFF_FFFF_FFFF_FFF0, 5, 10);
      do_branch(39'h3010, e_br_ge, 64'hFFFF_FFFF_FFFF_FFF0, 6, 12);
      repeat (5) @(negedge clk);
      check("t3_unconfirmed_v_o", v_o, 0);
      exp_q.push_back('{id: 1'b0, trip: 8'd128});
      do_confirm(1'b0);
      drain(6, "t3");

      // 4: distance 0x10000, stride 1 saturates.
      exp_q.push_back('{id: 1'b0, trip: 8'd255});
      do_start(1'b0, 39'h4000);
      do_confirm(1'b0);
      do_branch(39'h4020, e_br_ge, 64'hFFFF_FFFF_FFFF_FFE0, 0, 64'h10001);
      do_branch(39'h4020, e_br_ge, 64'hFFFF_FFFF_FFFF_FFE0, 1, 64'h10001);
      drain(200, "t4");

      // 5: one branch drives both channels into the divider together.
      do_start(1'b0, 39'h3000);
      do_start(1'b1, 39'h3000);
      do_confirm(1'b0);
      do_confirm(1'b1);
      hold_yumi = 1'b1;
      do_branch(39'h3010, e_br_ge, 64'hFFFF_FFFF_FFFF_FFF0, 0, 50);
      do_branch(39'h3010, e_br_ge, 64'hFFFF_FFFF_FFFF_FFF0, 2, 50);
      cyc = 0;
      while (!v_o && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("t5_first_v_o", v_o, 1);
      check("t5_first_id", id_o, 0);
      check("t5_first_trip", trip_o, 24);
      repeat (80) @(negedge clk);
      check("t5_held_v_o", v_o, 1);
      check("t5_held_id", id_o, 0);
      exp_q.push_back('{id: 1'b0, trip: 8'd24});
      exp_q.push_back('{id: 1'b1, trip: 8'd24});
      hold_yumi = 1'b0;
      drain(10, "t5");

      // 6a: start on a locked channel in DIV is ignored.
      exp_q.push_back('{id: 1'b0, trip: 8'd99});
      do_start(1'b0, 39'h6000);
      do_confirm(1'b0);
      do_branch(39'h6010, e_br_ge, 64'hFFFF_FFFF_FFFF_FFF0, 0, 400);
      do_branch(39'h6010, e_br_ge, 64'hFFFF_FFFF_FFFF_FFF0, 4, 400);
      repeat (5) @(negedge clk);
      do_start(1'b0, 39'h9000);
      drain(200, "t6a");

      // 6b: reset mid-division discards the pending result.
      do_start(1'b1, 39'h5000);
      do_confirm(1'b1);
      do_branch(39'h5010, e_br_ge, 64'hFFFF_FFFF_FFFF_FFF0, 0, 400);
      do_branch(39'h5010, e_br_ge, 64'hFFFF_FFFF_FFFF_FFF0, 4, 400);
      repeat (10) @(negedge clk);
      reset_i = 1'b1;
      @(negedge clk);
      check("t6_reset_v_o", v_o, 0);
      check("t6_reset_id_o", id_o, 0);
      check("t6_reset_trip_o", trip_o, 0);
      reset_i = 1'b0;
      seen = 0;
      repeat (100) begin
         @(negedge clk);
         if (v_o) seen = 1;
      end
      check("t6_no_result_after_reset", seen, 0);

      // Channel 1 works again after the reset.
      exp_q.push_back('{id: 1'b1, trip: 8'd128});
      do_start(1'b1, 39'h5000);
      do_confirm(1'b1);
      do_branch(39'h5010, e_br_ge, 64'hFFFF_FFFF_FFFF_FFF0, 1, 1);
      do_branch(39'h5010, e_br_ge, 64'hFFFF_FFFF_FFFF_FFF0, 1, 1);
      drain(10, "t6c");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bp_be_loop_trip_estimator.md
Name: bp_be_loop_trip_estimator

Overview:
- Multi-channel successor to the single-loop iteration inferrer in the BE checker.
- Tracks up to channels_p striding loads concurrently. Each channel locates the enclosing backward branch, samples its operands on two consecutive executions and computes the remaining trip count with a true iterative divider rather than a power-of-two shift.
- Sits beside the striding-load detector. Its results feed prefetch-depth control through a valid/yumi output port.

Parameters:
- bp_params_p, e_bp_default_cfg: processor config; supplies vaddr_width_p. dpath_width_gp comes from the package.
- channels_p, 2: number of independent loop trackers.
- output_range_p, 8: width of the trip-count result. Results saturate at 2^output_range_p-1.
- default_trip_p, 128: value reported when the trip count is indeterminate. Must fit in output_range_p.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- br_v_i  in  1  a resolved conditional branch is presented this cycle
- br_pc_i  in  vaddr_width_p  PC of that branch
- br_op_i  in  bp_be_loop_br_e  decoded compare: eq, ne, lt, ge, ltu, geu
- br_imm_i  in  dword_width_gp  sign-extended B immediate
- rs1_i, rs2_i  in  dpath_width_gp each  operand values of that branch
- start_v_i  in  1  begin discovery on channel start_id_i
- start_id_i  in  log2(channels_p)  channel to start
- striding_pc_i  in  vaddr_width_p  PC of the striding load
- confirm_v_i  in  1  lock channel confirm_id_i
- confirm_id_i  in  log2(channels_p)  channel to lock
- v_o  out  1  a result is available
- id_o  out  log2(channels_p)  channel that owns the result
- trip_o  out  output_range_p  remaining iterations
- yumi_i  in  1  consumer accepts the result; legal only while v_o is high

Behaviour:
- Reset: every channel goes to IDLE, unlocked, all registers zero. v_o=0, id_o=0, trip_o=0.
- Per-channel FSM states: IDLE, SEEK, ARMED, CALC, DIV, HOLD, READY.
- start_v_i: if the channel is unlocked, it clears, latches striding_pc_i and enters SEEK the next cycle. If the channel is locked, start is ignored.
- SEEK: on br_v_i with br_imm_i negative and target = (br_pc_i + br_imm_i) with bit0 cleared, and target <= striding pc:
  - latch pc and op;
  - latch the operands as the first sample; for lt/ltu the operands are swapped into ge form;
  - go to ARMED.
  Any other branch leaves the channel in SEEK.
- ARMED: on br_v_i with br_pc_i equal to the latched pc, latch the second sample and go to CALC. Other branches are ignored.
- CALC (1 cycle), using the second sample:
  - d1 = a2-a1, d2 = b2-b1, dist = |a2-b2|.
  - Indeterminate if both deltas are nonzero, or both are zero. In that case the result is default_trip_p and the channel goes directly to HOLD.
  - Otherwise stride = |nonzero delta|; request the divider.
- DIV: shared divider, one request granted per cycle, lowest channel index wins. Losing channels stay in DIV with the request held. Quotient is dist/stride, truncating, then saturated to output_range_p.
- HOLD: if locked, go to READY; otherwise wait for confirm.
- confirm_v_i: sets the lock in any state other than IDLE. It may arrive before HOLD, and the lock persists until the channel leaves READY.
- READY: the output mux presents the lowest-index READY channel. On yumi_i that channel returns to IDLE and unlocks the same cycle. Another READY channel is presented on the following cycle.
- Same-cycle events on one channel:
  - yumi_i and start_v_i: yumi wins; start is dropped.
  - confirm_v_i and start_v_i: start is applied, then the lock is set.
- One branch may advance several channels in the same cycle.
- reset_i mid-division aborts everything and returns to the reset state.

Decomposition:
- Shared package (bp_be_pkg): bp_be_loop_br_e and the channel state enum bp_be_loop_state_e.
- Sub-module bp_be_loop_trip_div: iterative restoring unsigned divider.
  - Handshake: v_i/ready_o in, v_o out.
  - Latency: dpath_width_gp+1 cycles. One operation at a time.
  - Divide-by-zero is unreachable by construction and asserted.

Test Plan:
1. Forward loop, striding pc 0x1000, bge at 0x1040 with imm -0x40. rs1: 3 then 4, rs2: 100 at both samples. Confirm issued. -> v_o=1, id_o=0, trip_o=96.
2. bltu, rs1=1000 fixed, rs2: 0 then 8. After swap to ge form: dist=992, stride=8. -> trip_o=124.
3. Both operands change (d1=1, d2=2). -> trip_o=128 after CALC with no DIV cycles.
4. Distance 0x10000 with stride 1 and output_range_p=8. -> trip_o=255 (saturated).
5. Both channels reach DIV in the same cycle. -> ch0 is granted first; ch1 follows after ch0's dpath_width_gp+1 cycles. Results are presented in order 0 then 1. Holding yumi_i=0 holds id_o=0 stable.
6. Channel locked in DIV, then start_v_i on the same id. -> start is ignored and the original result is still delivered. Asserting reset_i during DIV -> v_o=0 on the next cycle and all channels IDLE.
